// File: rtl/daq2_link_seq_pkg.sv
// Shared types and constants for the DAQ2 JESD204 link bring-up sequencer.
// Holds the state encoding, dwell-counter width and error-counter ceiling.
package daq2_link_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RST_XCVR    = 3'd1,
        ST_WAIT_LOCK   = 3'd2,
        ST_RST_LINK    = 3'd3,
        ST_WAIT_SYSREF = 3'd4,
        ST_WAIT_SYNC   = 3'd5,
        ST_RUN         = 3'd6,
        ST_FAIL        = 3'd7
    } state_t;

    // Wide enough for the largest timeout (65535 cycles).
    localparam int CNT_W = 16;

    localparam logic [15:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/daq2_link_seq_timer.sv
// Loadable down-counter shared by the reset, lock and sync dwells.
// Ports: clk, rst_n, load, value[CNT_W-1:0] in; done out (count is zero).
module daq2_link_seq_timer
    import daq2_link_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/daq2_link_seq.sv
// JESD204 link bring-up sequencer: xcvr reset, PLL lock, link reset, SYSREF, SYNC~.
// Ports: sys_clk, sys_reset_n, enable, pll_locked, cal_busy, sysref, sync_n in;
//        xcvr_reset, link_reset, sysref_en, link_ready, link_fail, state, retry_cnt, err_cnt out.
module daq2_link_seq
    import daq2_link_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 64,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int SYNC_TIMEOUT = 65535,
    parameter int SYNC_STABLE  = 16,
    parameter int SYSREF_COUNT = 2,
    parameter int MAX_RETRY    = 3
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        enable,
    input  logic        pll_locked,
    input  logic        cal_busy,
    input  logic        sysref,
    input  logic        sync_n,
    output logic        xcvr_reset,
    output logic        link_reset,
    output logic        sysref_en,
    output logic        link_ready,
    output logic        link_fail,
    output logic [2:0]  state,
    output logic [3:0]  retry_cnt,
    output logic [15:0] err_cnt
);

    localparam int SR_W = $clog2(SYSREF_COUNT + 1);
    localparam int SS_W = $clog2(SYNC_STABLE + 1);

    // Timer holds N-1 on entry so the dwell lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_TIMEOUT - 1);

    localparam logic [SR_W-1:0] SR_LAST   = SR_W'(SYSREF_COUNT - 1);
    localparam logic [SS_W-1:0] SS_FULL   = SS_W'(SYNC_STABLE);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);

    state_t           st;
    state_t           nxt;
    logic             fault;
    logic             sysref_q;
    logic             sr_rise;
    logic [SR_W-1:0]  sr_cnt;
    logic [SS_W-1:0]  ss_cnt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    daq2_link_seq_timer u_timer (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    assign sr_rise = sysref & ~sysref_q;
    assign state   = st;

    always_comb begin
        nxt   = st;
        fault = 1'b0;
        unique case (st)
            ST_IDLE:        if (enable) nxt = ST_RST_XCVR;
            ST_RST_XCVR:    if (tmr_done) nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // Success is tested first so it beats a same-cycle timeout.
                if (pll_locked && !cal_busy) nxt = ST_RST_LINK;
                else if (tmr_done)           fault = 1'b1;
            end
            ST_RST_LINK:    if (tmr_done) nxt = ST_WAIT_SYSREF;
            ST_WAIT_SYSREF: if (sr_rise && sr_cnt == SR_LAST) nxt = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
                if (ss_cnt == SS_FULL) nxt = ST_RUN;
                else if (tmr_done)     fault = 1'b1;
            end
            ST_RUN:         if (!pll_locked || !sync_n) fault = 1'b1;
            ST_FAIL:        nxt = ST_FAIL;
            default:        nxt = ST_IDLE;
        endcase
        if (fault) begin
            nxt = (retry_cnt == RETRY_MAX) ? ST_FAIL : ST_RST_XCVR;
        end
        if (!enable) begin
            nxt   = ST_IDLE;
            fault = 1'b0;
        end
    end

    // Reload the shared timer on every state change, sized for the new state.
    always_comb begin
        tmr_load = (nxt != st);
        tmr_val  = '0;
        unique case (nxt)
            ST_RST_XCVR,
            ST_RST_LINK:  tmr_val = RST_LD;
            ST_WAIT_LOCK: tmr_val = LOCK_LD;
            ST_WAIT_SYNC: tmr_val = SYNC_LD;
            default:      tmr_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            st         <= ST_IDLE;
            xcvr_reset <= 1'b1;
            link_reset <= 1'b1;
            sysref_en  <= 1'b0;
            link_ready <= 1'b0;
            link_fail  <= 1'b0;
            retry_cnt  <= '0;
            err_cnt    <= '0;
            sysref_q   <= 1'b0;
            sr_cnt     <= '0;
            ss_cnt     <= '0;
        end else begin
            st       <= nxt;
            sysref_q <= sysref;

            // Outputs follow the next state so they line up with `state`.
            xcvr_reset <= (nxt == ST_IDLE) || (nxt == ST_RST_XCVR) ||
                          (nxt == ST_FAIL);
            sysref_en  <= (nxt == ST_WAIT_SYSREF) || (nxt == ST_WAIT_SYNC) ||
                          (nxt == ST_RUN);
            link_reset <= !((nxt == ST_WAIT_SYSREF) || (nxt == ST_WAIT_SYNC) ||
                            (nxt == ST_RUN));
            link_ready <= (nxt == ST_RUN);
            link_fail  <= (nxt == ST_FAIL);

            if (st == ST_IDLE && nxt == ST_RST_XCVR) begin
                retry_cnt <= '0;
            end else if (fault && retry_cnt != RETRY_MAX) begin
                retry_cnt <= retry_cnt + 1'b1;
            end

            if (fault && err_cnt != ERR_SAT) begin
                err_cnt <= err_cnt + 1'b1;
            end

            if (st == ST_WAIT_SYSREF) begin
                if (sr_rise) sr_cnt <= sr_cnt + 1'b1;
            end else begin
                sr_cnt <= '0;
            end

            // Consecutive sync_n=1 cycles; any low sample restarts the run.
            if (st == ST_WAIT_SYNC) begin
                if (!sync_n)              ss_cnt <= '0;
                else if (ss_cnt != SS_FULL) ss_cnt <= ss_cnt + 1'b1;
            end else begin
                ss_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_daq2_link_seq.sv
// Directed testbench for daq2_link_seq.
// Drives bring-up, fault, enable, reset and timeout scenarios with exact-cycle checks.
module tb_daq2_link_seq;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pll_locked;
    logic        cal_busy;
    logic        sysref;
    logic        sync_n;
    logic        xcvr_reset;
    logic        link_reset;
    logic        sysref_en;
    logic        link_ready;
    logic        link_fail;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    daq2_link_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .SYNC_TIMEOUT (200),
        .SYNC_STABLE  (16),
        .SYSREF_COUNT (2),
        .MAX_RETRY    (3)
    ) dut (
        .sys_clk     (clk),
        .sys_reset_n (rst_n),
        .enable      (enable),
        .pll_locked  (pll_locked),
        .cal_busy    (cal_busy),
        .sysref      (sysref),
        .sync_n      (sync_n),
        .xcvr_reset  (xcvr_reset),
        .link_reset  (link_reset),
        .sysref_en   (sysref_en),
        .link_ready  (link_ready),
        .link_fail   (link_fail),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; outputs are read 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From a fresh RST_XCVR entry with pll_locked=1, land in WAIT_SYSREF.
    task automatic drive_to_sysref();
        step(4);
        step(1);
        step(4);
    endtask

    task automatic pulse_sysref();
        sysref = 1'b1; step(1);
        sysref = 1'b0; step(1);
        sysref = 1'b1; step(1);
        sysref = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pll_locked = 1'b0;
        cal_busy = 1'b0; sysref = 1'b0; sync_n = 1'b0;
        #12;
        n_checks++;
        if ({xcvr_reset, link_reset, sysref_en, link_ready, link_fail} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 11000",
                     {xcvr_reset, link_reset, sysref_en, link_ready, link_fail});
        end
        n_checks++;
        if ({state, retry_cnt, err_cnt} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_cnts: state=%0d retry=%0d err=%0d expected 0/0/0",
                     state, retry_cnt, err_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle: state=%0d expected 0", state);
        end
    endtask

    task automatic test_bringup();
        enable = 1'b1;
        step(1);
        n_checks++;
        if (state !== 3'd1 || xcvr_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_rst_xcvr: state=%0d xcvr=%b expected 1/1", state, xcvr_reset);
        end
        step(3);
        n_checks++;
        if (state !== 3'd1 || xcvr_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_xcvr_dwell: state=%0d xcvr=%b expected 1/1", state, xcvr_reset);
        end
        step(1);
        n_checks++;
        if (state !== 3'd2 || xcvr_reset !== 1'b0 || link_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_wait_lock: state=%0d xcvr=%b link=%b expected 2/0/1",
                     state, xcvr_reset, link_reset);
        end
        step(9);
        n_checks++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL bringup_lock_hold: state=%0d expected 2", state);
        end
        pll_locked = 1'b1;
        step(1);
        n_checks++;
        if (state !== 3'd3 || link_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_rst_link: state=%0d link=%b expected 3/1", state, link_reset);
        end
        step(3);
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL bringup_link_dwell: state=%0d expected 3", state);
        end
        step(1);
        n_checks++;
        if (state !== 3'd4 || link_reset !== 1'b0 || sysref_en !== 1'b1) begin
            n_fail++;
            $display("FAIL bringup_wait_sysref: state=%0d link=%b sren=%b expected 4/0/1",
                     state, link_reset, sysref_en);
        end
        sysref = 1'b1; step(1);
        sysref = 1'b0; step(1);
        n_checks++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL bringup_one_sysref: state=%0d expected 4", state);
        end
        sysref = 1'b1; step(1);
        sysref = 1'b0;
        n_checks++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL bringup_wait_sync: state=%0d expected 5", state);
        end
        sync_n = 1'b1;
        step(16);
        n_checks++;
        if (state !== 3'd5 || link_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bringup_sync_early: state=%0d ready=%b expected 5/0", state, link_ready);
        end
        step(1);
        n_checks++;
        if (state !== 3'd6 ||
            {xcvr_reset, link_reset, sysref_en, link_ready, link_fail} !== 5'b00110) begin
            n_fail++;
            $display("FAIL bringup_run: state=%0d outs=%b expected 6/00110", state,
                     {xcvr_reset, link_reset, sysref_en, link_ready, link_fail});
        end
        n_checks++;
        if (err_cnt !== 16'd0 || retry_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL bringup_cnts: err=%0d retry=%0d expected 0/0", err_cnt, retry_cnt);
        end
        step(5);
        n_checks++;
        if (state !== 3'd6) begin
            n_fail++;
            $display("FAIL bringup_run_hold: state=%0d expected 6", state);
        end
    endtask

    task automatic test_run_fault();
        sync_n = 1'b0;
        step(1);
        sync_n = 1'b1;
        n_checks++;
        if (state !== 3'd1 || link_ready !== 1'b0 || xcvr_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL run_fault_state: state=%0d ready=%b xcvr=%b expected 1/0/1",
                     state, link_ready, xcvr_reset);
        end
        n_checks++;
        if (err_cnt !== 16'd1 || retry_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL run_fault_cnts: err=%0d retry=%0d expected 1/1", err_cnt, retry_cnt);
        end
    endtask

    task automatic test_enable_drop();
        drive_to_sysref();
        n_checks++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL en_drop_setup: state=%0d expected 4", state);
        end
        enable = 1'b0;
        step(1);
        n_checks++;
        if (state !== 3'd0 ||
            {xcvr_reset, link_reset, sysref_en, link_ready, link_fail} !== 5'b11000) begin
            n_fail++;
            $display("FAIL en_drop_idle: state=%0d outs=%b expected 0/11000", state,
                     {xcvr_reset, link_reset, sysref_en, link_ready, link_fail});
        end
        n_checks++;
        if (retry_cnt !== 4'd1 || err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL en_drop_held: retry=%0d err=%0d expected 1/1", retry_cnt, err_cnt);
        end
        enable = 1'b1;
        step(1);
        n_checks++;
        if (state !== 3'd1 || retry_cnt !== 4'd0 || err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL en_restart: state=%0d retry=%0d err=%0d expected 1/0/1",
                     state, retry_cnt, err_cnt);
        end
    endtask

    task automatic test_sync_toggle();
        logic stayed;
        sync_n = 1'b0;
        drive_to_sysref();
        pulse_sysref();
        n_checks++;
        if (state !== 3'd5) begin
            n_fail++;
            $display("FAIL toggle_setup: state=%0d expected 5", state);
        end
        stayed = 1'b1;
        for (int k = 0; k < 200; k++) begin
            sync_n = ((k / 10) % 2) != 0;
            step(1);
            if (k < 199 && state !== 3'd5) stayed = 1'b0;
        end
        n_checks++;
        if (stayed !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_stay: left WAIT_SYNC early, got 0 expected 1");
        end
        n_checks++;
        if (state !== 3'd1 || err_cnt !== 16'd2 || retry_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL toggle_timeout: state=%0d err=%0d retry=%0d expected 1/2/1",
                     state, err_cnt, retry_cnt);
        end
    endtask

    task automatic test_async_reset();
        sync_n = 1'b1;
        pll_locked = 1'b1;
        drive_to_sysref();
        pulse_sysref();
        step(17);
        n_checks++;
        if (state !== 3'd6) begin
            n_fail++;
            $display("FAIL areset_setup: state=%0d expected 6", state);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({xcvr_reset, link_reset, sysref_en, link_ready, link_fail} !== 5'b11000 ||
            state !== 3'd0) begin
            n_fail++;
            $display("FAIL areset_outs: state=%0d outs=%b expected 0/11000", state,
                     {xcvr_reset, link_reset, sysref_en, link_ready, link_fail});
        end
        n_checks++;
        if (err_cnt !== 16'd0 || retry_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_cnts: err=%0d retry=%0d expected 0/0", err_cnt, retry_cnt);
        end
        enable = 1'b0;
        #2;
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (state !== 3'd0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_release: state=%0d err=%0d expected 0/0", state, err_cnt);
        end
    endtask

    task automatic test_lock_timeout();
        logic [2:0] exp_st;
        logic [3:0] exp_retry;
        pll_locked = 1'b0;
        enable = 1'b1;
        step(1);
        n_checks++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL lock_start: state=%0d expected 1", state);
        end
        for (int r = 0; r < 4; r++) begin
            step(4);
            n_checks++;
            if (state !== 3'd2) begin
                n_fail++;
                $display("FAIL lock_enter_r%0d: state=%0d expected 2", r, state);
            end
            step(99);
            n_checks++;
            if (state !== 3'd2) begin
                n_fail++;
                $display("FAIL lock_hold_r%0d: state=%0d expected 2", r, state);
            end
            step(1);
            exp_st    = (r < 3) ? 3'd1 : 3'd7;
            exp_retry = (r < 3) ? 4'(r + 1) : 4'd3;
            n_checks++;
            if (state !== exp_st || err_cnt !== 16'(r + 1) || retry_cnt !== exp_retry) begin
                n_fail++;
                $display("FAIL lock_timeout_r%0d: state=%0d err=%0d retry=%0d expected %0d/%0d/%0d",
                         r, state, err_cnt, retry_cnt, exp_st, r + 1, exp_retry);
            end
        end
        n_checks++;
        if ({xcvr_reset, link_reset, sysref_en, link_ready, link_fail} !== 5'b11001) begin
            n_fail++;
            $display("FAIL fail_outs: got %b expected 11001",
                     {xcvr_reset, link_reset, sysref_en, link_ready, link_fail});
        end
        step(5);
        n_checks++;
        if (state !== 3'd7) begin
            n_fail++;
            $display("FAIL fail_hold: state=%0d expected 7", state);
        end
        enable = 1'b0;
        step(1);
        n_checks++;
        if (state !== 3'd0 || link_fail !== 1'b0 || retry_cnt !== 4'd3 || err_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL fail_exit: state=%0d fail=%b retry=%0d err=%0d expected 0/0/3/4",
                     state, link_fail, retry_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_run_fault();
        test_enable_drop();
        test_sync_toggle();
        test_async_reset();
        test_lock_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
